stepper_ramp_ctrl: RTL and testbench
====================================

# stepper_ramp_ctrl

Parametrised move controller for a DRV8825-class stepper driver. It replaces fixed-rate free-running stepping with counted moves:
- accepts a move command (step count plus direction);
- ramps step rate up and down linearly in period;
- exposes busy/done status to the surrounding FPGA logic.

It sits between user/control logic and the STEP/DIR/ENABLE driver pins.

## Interface
- CNT_W, 32, width of period/cycle counters
- POS_W, 24, width of step count, position and ramp counters
- MAX_PERIOD, 20000, start/stop step period in clk cycles
- MIN_PERIOD, 5000, cruise (fastest) step period in clk cycles
- ACCEL_STEP, 250, period change per step while ramping
- PULSE_W, 100, STEP high time in clk cycles
- DIR_SETUP, 50, cycles DIR is held stable before the first STEP rise
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; 1 = driver enabled, 0 = hard stop
- start  in  1  single-cycle move request
- dir_in  in  1  move direction, sampled with start (0 = CW, 1 = CCW)
- target_steps  in  POS_W  step count, sampled with start
- abort  in  1  single-cycle request for a controlled decelerating stop
- step  out  1  STEP pin
- dir  out  1  DIR pin
- enable_n  out  1  driver ENABLE, active low
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at end of a move (normal or aborted)
- steps_done  out  POS_W  steps issued in the current or last move

## Operation
- **Legal parameters:** PULSE_W ≥ 1; MIN_PERIOD > PULSE_W; MAX_PERIOD ≥ MIN_PERIOD; MAX_PERIOD < 2^CNT_W.
- **Reset values:** all outputs 0 except enable_n = 1. Internal state: period = MAX_PERIOD, ramp_cnt = 0, state IDLE.
- **enable_n:** registered ~en every cycle.
- **States:**
  - IDLE: start && en → SETUP. Latch dir_in into dir, latch target_steps, clear steps_done, set period = MAX_PERIOD, set ramp_cnt = 0. If target_steps = 0 → DONE instead of SETUP.
  - SETUP: count DIR_SETUP cycles → PULSE.
  - PULSE: step = 1 for PULSE_W cycles. In the first PULSE cycle:
    - increment steps_done (new value k);
    - compute rem = target − k and update period per the ramp rule.
    - After PULSE_W cycles: rem = 0 → DONE, else → GAP.
  - GAP: step = 0 until the interval since the last STEP rise reaches the updated period → PULSE.
  - DONE: done = 1 for one cycle; busy = 0 → IDLE.
- **Ramp rule,** evaluated in order at each step rise:
  - If rem ≤ ramp_cnt and ramp_cnt > 0: decelerate. ramp_cnt−1; period = min(period + ACCEL_STEP, MAX_PERIOD).
  - Else if period > MIN_PERIOD: accelerate. ramp_cnt+1; period = max(period − ACCEL_STEP, MIN_PERIOD).
  - Else: cruise, period unchanged.
- **Arithmetic:** period arithmetic uses CNT_W+1 bits internally, so neither clamp can wrap.
- **Abort:** accepted only in SETUP/PULSE/GAP.
  - In SETUP: go directly to DONE; no step is issued.
  - Otherwise: target is overwritten with steps_done + ramp_cnt, plus 1 if abort lands in GAP with ramp_cnt = 0, so the move always completes its current step.
  - Deceleration then follows the normal rule.
- **Ignored inputs:** start while busy is ignored. abort in IDLE/DONE is ignored.
- **Hard stop:** en = 0 in any state → step = 0 and busy = 0 next cycle; state IDLE; no done pulse. steps_done is held.
- **dir:** changes only on an accepted start.

## Timing
- start accepted in cycle 0 → busy = 1 and dir valid in cycle 1. First STEP rise in cycle 1 + DIR_SETUP.
- STEP rise-to-rise interval equals the period computed at the earlier rise. STEP high is exactly PULSE_W cycles.
- done and busy deassertion occur in the cycle after the final STEP falls.
- steps_done updates in the cycle after each STEP rise.
- Simultaneous start and abort in IDLE: start wins.
- Simultaneous abort and en = 0: hard stop wins.
- rst_n mid-move: outputs return to reset values immediately, with no STEP glitch high.

## Structure
- Shared package stepper_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, GAP, DONE);
  - the default timing constants.
- Sub-module stepper_ramp_gen: combinational/registered period and ramp_cnt update, taking period, ramp_cnt and rem.
- The top level holds the FSM and the cycle/step counters.

## Test plan
All scenarios use MAX_PERIOD = 10, MIN_PERIOD = 4, ACCEL_STEP = 2, PULSE_W = 2, DIR_SETUP = 3 unless stated.
- **Ramped move:** target 6, dir_in = 1 → dir = 1 from cycle 1. STEP rises at cycles 4, 12, 18, 22, 28, 36 (intervals 8, 6, 4, 6, 8). done at cycle 39; steps_done = 6.
- **Zero-length move:** target 0 → no STEP edge; done pulse in cycle 1; busy high one cycle.
- **Abort at full speed:** target 100, abort one cycle after the 4th rise. Exactly 3 further STEP rises at intervals 6, 8, then done; steps_done = 7.
- **Hard stop:** en dropped during a PULSE high. step = 0 and busy = 0 the next cycle; enable_n = 1; no done pulse.
- **Ignored start:** second start with dir_in flipped mid-move → dir and step timing unchanged; busy remains until the original target completes.
- **Reset mid-move:** rst_n asserted during GAP, then released. Outputs are at reset values immediately (step = 0, enable_n = 1, busy = 0). The next move starts again at period 10.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared state encoding and default timing constants for the stepper move controller.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned DEF_POS_W      = 24;
  localparam int unsigned DEF_MAX_PERIOD = 20000;
  localparam int unsigned DEF_MIN_PERIOD = 5000;
  localparam int unsigned DEF_ACCEL_STEP = 250;
  localparam int unsigned DEF_PULSE_W    = 100;
  localparam int unsigned DEF_DIR_SETUP  = 50;

endpackage

// File: rtl/stepper_ramp_gen.sv
// Linear ramp rule: decides the next step period and ramp depth at each STEP rise.
module stepper_ramp_gen
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned POS_W      = DEF_POS_W,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned ACCEL_STEP = DEF_ACCEL_STEP
) (
  input  logic [CNT_W-1:0] period,
  input  logic [POS_W-1:0] ramp_cnt,
  input  logic [POS_W-1:0] rem,
  output logic [CNT_W-1:0] period_nxt,
  output logic [POS_W-1:0] ramp_nxt
);

  // One extra bit so neither the add nor the subtract can wrap before clamping.
  localparam logic [CNT_W:0]   MAX_X = (CNT_W+1)'(MAX_PERIOD);
  localparam logic [CNT_W:0]   MIN_X = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   ACC_X = (CNT_W+1)'(ACCEL_STEP);
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  logic [CNT_W:0] period_x;
  logic [CNT_W:0] up;
  logic [CNT_W:0] dn;

  always_comb begin
    period_x   = {1'b0, period};
    up         = period_x + ACC_X;
    dn         = period_x - ACC_X;
    period_nxt = period;
    ramp_nxt   = ramp_cnt;
    if ((rem <= ramp_cnt) && (ramp_cnt != '0)) begin
      ramp_nxt   = ramp_cnt - POS_W'(1);
      period_nxt = (up > MAX_X) ? MAX_P : up[CNT_W-1:0];
    end else if (period_x > MIN_X) begin
      ramp_nxt   = ramp_cnt + POS_W'(1);
      period_nxt = (dn[CNT_W] || (dn < MIN_X)) ? MIN_P : dn[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Counted-move controller for a STEP/DIR stepper driver with linear period ramps.
module stepper_ramp_ctrl
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned POS_W      = DEF_POS_W,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned ACCEL_STEP = DEF_ACCEL_STEP,
  parameter int unsigned PULSE_W    = DEF_PULSE_W,
  parameter int unsigned DIR_SETUP  = DEF_DIR_SETUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             dir_in,
  input  logic [POS_W-1:0] target_steps,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             enable_n,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] steps_done
);

  localparam logic [CNT_W-1:0] MAX_P       = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'((DIR_SETUP == 0) ? 0 : DIR_SETUP - 1);
  localparam state_e           FIRST_STATE = (DIR_SETUP == 0) ? PULSE : SETUP;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_cnt, period_q, gen_period;
  logic [POS_W-1:0] ramp_q, gen_ramp, target_q;
  logic [POS_W-1:0] rem_now, rem_rise, steps_nxt, ramp_upd;
  logic             first_pulse, accept, abort_ok, cnt_clr;

  // start is a one-cycle request, taken only in IDLE with the driver enabled.
  assign accept      = (state_q == IDLE) && start && en;
  assign first_pulse = (state_q == PULSE) && (cyc_cnt == '0);
  assign rem_now     = target_q - steps_done;
  assign rem_rise    = target_q - steps_done - POS_W'(1);
  assign steps_nxt   = first_pulse ? steps_done + POS_W'(1) : steps_done;
  assign ramp_upd    = first_pulse ? gen_ramp : ramp_q;
  // The trailing GAP cycle after the final step has nothing left to shorten.
  assign abort_ok    = abort && en &&
                       ((state_q == SETUP) || (state_q == PULSE) ||
                        ((state_q == GAP) && (rem_now != '0)));
  assign cnt_clr     = ((state_d != state_q) && (state_d != GAP)) || (state_d == IDLE);

  stepper_ramp_gen #(
    .CNT_W      (CNT_W),
    .POS_W      (POS_W),
    .MAX_PERIOD (MAX_PERIOD),
    .MIN_PERIOD (MIN_PERIOD),
    .ACCEL_STEP (ACCEL_STEP)
  ) u_ramp (
    .period     (period_q),
    .ramp_cnt   (ramp_q),
    .rem        (rem_rise),
    .period_nxt (gen_period),
    .ramp_nxt   (gen_ramp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (target_steps == '0) ? DONE : FIRST_STATE;
        SETUP:   if (abort_ok) state_d = DONE;
                 else if (cyc_cnt == SETUP_LAST) state_d = PULSE;
        PULSE:   if (cyc_cnt == PULSE_LAST) state_d = GAP;
        GAP:     if (rem_now == '0) state_d = DONE;
                 else if (cyc_cnt == period_q - CNT_W'(1)) state_d = PULSE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // cyc_cnt runs across PULSE into GAP so it measures rise-to-rise spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step       <= 1'b0;
      dir        <= 1'b0;
      enable_n   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_done <= '0;
      cyc_cnt    <= '0;
      period_q   <= MAX_P;
      ramp_q     <= '0;
      target_q   <= '0;
    end else begin
      enable_n <= ~en;
      step     <= (state_d == PULSE);
      done     <= (state_d == DONE);
      busy     <= (state_d == SETUP) || (state_d == PULSE) || (state_d == GAP) || accept;
      cyc_cnt  <= cnt_clr ? '0 : cyc_cnt + CNT_W'(1);
      if (accept) begin
        dir        <= dir_in;
        target_q   <= target_steps;
        steps_done <= '0;
        period_q   <= MAX_P;
        ramp_q     <= '0;
      end else begin
        if (first_pulse) begin
          steps_done <= steps_nxt;
          period_q   <= gen_period;
          ramp_q     <= gen_ramp;
        end
        if (abort_ok && (state_q == PULSE))
          target_q <= steps_nxt + ramp_upd;
        else if (abort_ok && (state_q == GAP))
          target_q <= steps_done + ramp_q + POS_W'(ramp_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Bench for stepper_ramp_ctrl: table of moves with hand-derived STEP rise times plus corner sequences.
module tb_stepper_ramp_ctrl;

  localparam int CNT_W = 32;
  localparam int POS_W = 24;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic             dir_in = 1'b0;
  logic [POS_W-1:0] target_steps = '0;
  logic             abort = 1'b0;
  logic             step, dir, enable_n, busy, done;
  logic [POS_W-1:0] steps_done;

  stepper_ramp_ctrl #(
    .CNT_W      (CNT_W),
    .POS_W      (POS_W),
    .MAX_PERIOD (10),
    .MIN_PERIOD (4),
    .ACCEL_STEP (2),
    .PULSE_W    (2),
    .DIR_SETUP  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .start        (start),
    .dir_in       (dir_in),
    .target_steps (target_steps),
    .abort        (abort),
    .step         (step),
    .dir          (dir),
    .enable_n     (enable_n),
    .busy         (busy),
    .done         (done),
    .steps_done   (steps_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required reaching the summary");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int target;
    bit dir_v;
    int abort_at;
    int done_at;
    int steps;
    bit busyd;
    int n_rise;
    int rise[8];
  } vec_t;

  vec_t vecs[9];

  logic [31:0]      exp_q[$];
  logic [31:0]      exp_done_q[$];
  logic [POS_W-1:0] exp_steps_q[$];
  logic             exp_busyd_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int rise_base = 0;
  int done_cnt = 0;
  int hi_cnt = 0;
  int exp_width = 2;
  bit exp_dir = 1'b0;
  bit prev_step = 1'b0;
  bit rose_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    if (!rst_n) begin
      prev_step = 1'b0;
      rose_last = 1'b0;
      hi_cnt    = 0;
    end else begin
      if (rose_last) check("steps_after_rise", steps_done, rise_cnt - rise_base);
      rose_last = 1'b0;
      if (step && !prev_step) begin
        rose_last = 1'b1;
        rise_cnt++;
        hi_cnt = 0;
        check("rise_dir", dir, exp_dir);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rise: STEP rose at cycle %0d, no rise expected", cyc);
        end else begin
          check("rise_cycle", cyc, exp_q.pop_front());
        end
      end
      if (step) hi_cnt++;
      if (!step && prev_step) check("pulse_width", hi_cnt, exp_width);
      prev_step = step;
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, no done expected", cyc);
        end else begin
          check("done_cycle", cyc, exp_done_q.pop_front());
          check("done_steps", steps_done, exp_steps_q.pop_front());
          check("done_busy", busy, exp_busyd_q.pop_front());
        end
      end
    end
  endtask

  // Samples at the falling edge, then returns just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic vec_t mk(input int target, input bit d, input int ab, input int done_at,
                              input int steps, input bit busyd, input int n,
                              input int r0, input int r1, input int r2, input int r3,
                              input int r4, input int r5, input int r6);
    vec_t v;
    v.target   = target;
    v.dir_v    = d;
    v.abort_at = ab;
    v.done_at  = done_at;
    v.steps    = steps;
    v.busyd    = busyd;
    v.n_rise   = n;
    v.rise     = '{r0, r1, r2, r3, r4, r5, r6, 0};
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int restart_at);
    int dbase;
    dbase     = done_cnt;
    rise_base = rise_cnt;
    exp_dir   = v.dir_v;
    for (int i = 0; i < v.n_rise; i++) exp_q.push_back(cyc + v.rise[i]);
    exp_done_q.push_back(cyc + v.done_at);
    exp_steps_q.push_back(POS_W'(v.steps));
    exp_busyd_q.push_back(v.busyd);
    start        = 1'b1;
    dir_in       = v.dir_v;
    target_steps = POS_W'(v.target);
    abort        = (v.abort_at == 0);
    tick();
    start        = 1'b0;
    abort        = 1'b0;
    dir_in       = ~v.dir_v;
    target_steps = POS_W'(3);
    check("busy_cycle1", busy, 1);
    check("dir_cycle1", dir, v.dir_v);
    for (int r = 1; r < 200 && done_cnt == dbase; r++) begin
      start = (r == restart_at);
      abort = (r == v.abort_at);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    if (done_cnt == dbase) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within 200 cycles, expected done at +%0d", v.done_at);
    end
    tick();
    tick();
    check("rises_left", exp_q.size(), 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int dbase;
    vecs[0] = mk(6,   1'b1, -1, 39, 6, 1'b0, 6, 4, 12, 18, 22, 28, 36, 0);
    vecs[1] = mk(0,   1'b0, -1,  1, 0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mk(100, 1'b1, 23, 43, 7, 1'b0, 7, 4, 12, 18, 22, 26, 32, 40);
    vecs[3] = mk(100, 1'b0, 22, 43, 7, 1'b0, 7, 4, 12, 18, 22, 26, 32, 40);
    vecs[4] = mk(1,   1'b1, -1,  7, 1, 1'b0, 1, 4, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk(3,   1'b0, -1, 25, 3, 1'b0, 3, 4, 12, 22, 0, 0, 0, 0);
    vecs[6] = mk(5,   1'b1,  2,  3, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk(100, 1'b0,  8, 15, 2, 1'b0, 2, 4, 12, 0, 0, 0, 0, 0);
    vecs[8] = mk(2,   1'b1,  0, 15, 2, 1'b0, 2, 4, 12, 0, 0, 0, 0, 0);

    // reset values
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_enable_n", enable_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_steps", steps_done, 0);
    rst_n = 1'b1;
    tick();
    check("enable_n_follows_en", enable_n, 0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i], -1);

    // second start with flipped direction while moving is ignored
    run_vec(vecs[0], 8);

    // abort while idle does nothing
    dbase = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    check("idle_abort_busy", busy, 0);
    check("idle_abort_no_done", done_cnt, dbase);

    // hard stop during the second STEP high
    dbase     = done_cnt;
    rise_base = rise_cnt;
    exp_dir   = 1'b1;
    exp_q.push_back(cyc + 4);
    exp_q.push_back(cyc + 12);
    start        = 1'b1;
    dir_in       = 1'b1;
    target_steps = POS_W'(100);
    tick();
    start = 1'b0;
    repeat (11) tick();
    en        = 1'b0;
    exp_width = 1;
    tick();
    check("hard_step", step, 0);
    check("hard_busy", busy, 0);
    check("hard_enable_n", enable_n, 1);
    check("hard_done", done, 0);
    repeat (10) tick();
    check("hard_steps_held", steps_done, 2);
    check("hard_rises_left", exp_q.size(), 0);
    check("hard_no_done", done_cnt, dbase);
    en        = 1'b1;
    exp_width = 2;
    tick();
    tick();

    // reset in the middle of a GAP
    rise_base = rise_cnt;
    exp_dir   = 1'b1;
    exp_q.push_back(cyc + 4);
    start        = 1'b1;
    dir_in       = 1'b1;
    target_steps = POS_W'(6);
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_step", step, 0);
    check("midrst_enable_n", enable_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_steps", steps_done, 0);
    check("midrst_rises_left", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    run_vec(vecs[5], -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
